seq_divider: RTL and testbench

Multi-cycle 32-bit integer divider for the RISC_KGP ALU, sitting directly downstream of the two's-complement negation stage. It consumes sign-resolved operands, takes magnitudes through the same negation path, runs a 32-iteration restoring division, and re-applies signs to the quotient and remainder. The ALU control unit drives it through a start/done handshake and stalls while `busy` is high.

---
 rtl/seq_divider.sv | 199 +++++++++++++++++++
 tb/tb_seq_divider.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//
// Multi-cycle integer divider for the ALU. It takes the magnitudes of the
// operands, runs a restoring division one quotient bit per cycle, and then
// re-applies the signs to the quotient and remainder. The control unit drives
// it with a start/done handshake and stalls while busy is high.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        request a division (accepted only when idle)
//   signed_op    1 = two's complement division, 0 = unsigned
//   dividend     numerator, sampled with start
//   divisor      denominator, sampled with start
//   quotient     result quotient, held until the next accepted start
//   remainder    result remainder, held until the next accepted start
//   busy         high from the cycle after an accepted start up to and
//                including the done cycle
//   done         one-cycle pulse, results valid
//   div_by_zero  divisor was zero, held with the results
// ---------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS,
    S_ITER,
    S_SIGN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // dvd_q holds the dividend; during the iterations it shifts left and the
  // quotient bits fill in from the bottom, so it ends up holding Q.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   pr_q, pr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             sgn_q, sgn_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   shifted_pr;
  logic [WIDTH:0]   trial;
  logic             dvd_neg;
  logic             dvs_neg;

  // Datapath helpers shared by the ABS and ITER states.
  assign shifted_pr = {pr_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  assign trial      = shifted_pr - {1'b0, dvs_q};
  assign dvd_neg    = sgn_q & dvd_q[WIDTH-1];
  assign dvs_neg    = sgn_q & dvs_q[WIDTH-1];

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    pr_d    = pr_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dbz_d   = dbz_q;
    busy_d  = busy_q;
    // done is registered one cycle behind the DONE state so the pulse lands
    // on the cycle after the DONE edge; busy drops together with it.
    done_d  = (state_q == S_DONE);
    if (done_q) begin
      busy_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        // The cycle carrying the done pulse still counts as the tail of the
        // previous operation, so a start there is ignored.
        if (start && !done_q) begin
          dvd_d  = dividend;
          dvs_d  = divisor;
          sgn_d  = signed_op;
          busy_d = 1'b1;
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            quot_d  = '0;
            rem_d   = '0;
            dbz_d   = 1'b0;
            state_d = S_ABS;
          end
        end
      end

      S_ABS: begin
        dvd_d   = dvd_neg ? -dvd_q : dvd_q;
        dvs_d   = dvs_neg ? -dvs_q : dvs_q;
        qneg_d  = dvd_neg ^ dvs_neg;
        rneg_d  = dvd_neg;
        pr_d    = '0;
        cnt_d   = CW'(WIDTH - 1);
        state_d = S_ITER;
      end

      S_ITER: begin
        // A clear top bit on the 33-bit trial means the divisor fits.
        if (!trial[WIDTH]) begin
          pr_d  = trial;
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          pr_d  = shifted_pr;
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = S_SIGN;
        end
      end

      S_SIGN: begin
        quot_d  = qneg_q ? -dvd_q : dvd_q;
        rem_d   = rneg_q ? -pr_q[WIDTH-1:0] : pr_q[WIDTH-1:0];
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      pr_q    <= pr_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
//
// Bench for seq_divider: directed cases, randomized operations against a
// plain-arithmetic reference, an ignored mid-flight start, and a reset abort.
// ---------------------------------------------------------------------------
module tb_seq_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: integer division with 64-bit arithmetic, which truncates toward
  // zero and gives the remainder the dividend's sign.
  function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic z);
    longint la;
    longint lb;
    if (b == 32'd0) begin
      q = 32'hFFFFFFFF;
      r = a;
      z = 1'b1;
    end else begin
      if (s) begin
        la = longint'($signed(a));
        lb = longint'($signed(b));
      end else begin
        la = longint'({32'd0, a});
        lb = longint'({32'd0, b});
      end
      q = 32'(la / lb);
      r = 32'(la % lb);
      z = 1'b0;
    end
  endfunction

  // Issues one start and waits (bounded) for done. lat counts rising edges
  // from the start edge to the edge after which done is seen high.
  task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic z,
                         output int lat, output bit busy_ok, output bit clr_ok,
                         output bit tail_ok);
    @(negedge clk);
    start     = 1'b1;
    signed_op = s;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    signed_op = ~s;
    busy_ok   = (busy === 1'b1);
    clr_ok    = (b == 32'd0) ||
                (quotient === 32'd0 && remainder === 32'd0 && div_by_zero === 1'b0);
    lat = 0;
    while (lat < 200 && done !== 1'b1) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
    @(posedge clk);
    #1;
    tail_ok = (done === 1'b0) && (busy === 1'b0) && (quotient === q) &&
              (remainder === r) && (div_by_zero === z);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    signed_op = 1'b0;
    dividend = 32'd0;
    divisor = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (quotient !== 32'd0) begin errors++; $display("FAIL reset_quotient got=%h exp=0", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    rst = 1'b0;
    $display("reset: outputs q=%h r=%h busy=%b done=%b dbz=%b", quotient, remainder, busy, done, div_by_zero);
  endtask

  task automatic test_directed();
    bit          s_t [7]   = '{1, 1, 1, 1, 0, 1, 0};
    logic [31:0] a_t [7]   = '{32'd100, 32'hFFFFFF9C, 32'd100, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1234};
    logic [31:0] b_t [7]   = '{32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd0};
    logic [31:0] q_t [7]   = '{32'd14, 32'hFFFFFFF2, 32'hFFFFFFF2, 32'h80000000, 32'h7FFFFFFF, 32'd0, 32'hFFFFFFFF};
    logic [31:0] r_t [7]   = '{32'd2, 32'hFFFFFFFE, 32'd2, 32'd0, 32'd1, 32'hFFFFFFFF, 32'd1234};
    logic        z_t [7]   = '{0, 0, 0, 0, 0, 0, 1};
    int          l_t [7]   = '{35, 35, 35, 35, 35, 35, 1};
    logic [31:0] q, r;
    logic        z;
    int          lat;
    bit          busy_ok, clr_ok, tail_ok;
    for (int i = 0; i < 7; i++) begin
      run_div(s_t[i], a_t[i], b_t[i], q, r, z, lat, busy_ok, clr_ok, tail_ok);
      $display("directed %0d: s=%0b %h / %h -> q=%h r=%h dbz=%b lat=%0d", i, s_t[i], a_t[i], b_t[i], q, r, z, lat);
      checks++; if (q !== q_t[i]) begin errors++; $display("FAIL dir%0d_quotient got=%h exp=%h", i, q, q_t[i]); end
      checks++; if (r !== r_t[i]) begin errors++; $display("FAIL dir%0d_remainder got=%h exp=%h", i, r, r_t[i]); end
      checks++; if (z !== z_t[i]) begin errors++; $display("FAIL dir%0d_dbz got=%b exp=%b", i, z, z_t[i]); end
      checks++; if (lat !== l_t[i]) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, l_t[i]); end
      checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL dir%0d_busy_span got=%b exp=1", i, busy_ok); end
      checks++; if (clr_ok !== 1'b1) begin errors++; $display("FAIL dir%0d_clear_on_start got=%b exp=1", i, clr_ok); end
      checks++; if (tail_ok !== 1'b1) begin errors++; $display("FAIL dir%0d_pulse_hold got=%b exp=1", i, tail_ok); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r, eq, er;
    logic        z, ez;
    bit          s;
    int          lat;
    bit          busy_ok, clr_ok, tail_ok;
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      a = (i % 7 == 3) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        2:       b = 32'($urandom_range(1, 15));
        3:       b = 32'($urandom_range(1, 65535));
        default: b = $urandom;
      endcase
      ref_div(s, a, b, eq, er, ez);
      run_div(s, a, b, q, r, z, lat, busy_ok, clr_ok, tail_ok);
      $display("random %0d: s=%0b %h / %h -> q=%h r=%h dbz=%b lat=%0d", i, s, a, b, q, r, z, lat);
      checks++; if (q !== eq) begin errors++; $display("FAIL rnd%0d_quotient got=%h exp=%h", i, q, eq); end
      checks++; if (r !== er) begin errors++; $display("FAIL rnd%0d_remainder got=%h exp=%h", i, r, er); end
      checks++; if (z !== ez) begin errors++; $display("FAIL rnd%0d_dbz got=%b exp=%b", i, z, ez); end
      checks++; if (lat !== (ez ? 1 : 35)) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, ez ? 1 : 35); end
      checks++; if (busy_ok !== 1'b1 || tail_ok !== 1'b1) begin errors++; $display("FAIL rnd%0d_handshake busy_ok=%b tail_ok=%b exp=1/1", i, busy_ok, tail_ok); end
    end
  endtask

  task automatic test_ignore_start();
    int n;
    int extra;
    @(negedge clk);
    start = 1'b1; signed_op = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (n < 200 && done !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 9) begin
        start = 1'b1; signed_op = 1'b0; dividend = 32'd9; divisor = 32'd3;
      end else if (n == 10) begin
        start = 1'b0;
      end
    end
    $display("ignore_start: q=%h r=%h lat=%0d", quotient, remainder, n);
    checks++; if (n !== 35) begin errors++; $display("FAIL ign_latency got=%0d exp=35", n); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL ign_quotient got=%h exp=%h", quotient, 32'd14); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL ign_remainder got=%h exp=%h", remainder, 32'd2); end
    extra = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) extra++;
    end
    $display("ignore_start: extra done pulses=%0d", extra);
    checks++; if (extra !== 0) begin errors++; $display("FAIL ign_second_done got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_abort();
    int n;
    int seen;
    logic [31:0] q, r;
    logic        z;
    int          lat;
    bit          busy_ok, clr_ok, tail_ok;
    @(negedge clk);
    start = 1'b1; signed_op = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    seen = 0;
    for (n = 1; n <= 19; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    $display("reset_abort: q=%h r=%h busy=%b done=%b dbz=%b", quotient, remainder, busy, done, div_by_zero);
    checks++; if ({quotient, remainder, busy, done, div_by_zero} !== 67'd0) begin errors++; $display("FAIL abort_outputs got q=%h r=%h b=%b d=%b z=%b exp=all 0", quotient, remainder, busy, done, div_by_zero); end
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_done got=%0d exp=0", seen); end
    run_div(1'b0, 32'd9, 32'd3, q, r, z, lat, busy_ok, clr_ok, tail_ok);
    $display("reset_abort: fresh 9/3 -> q=%h r=%h lat=%0d", q, r, lat);
    checks++; if (q !== 32'd3) begin errors++; $display("FAIL abort_fresh_quotient got=%h exp=%h", q, 32'd3); end
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL abort_fresh_remainder got=%h exp=0", r); end
    checks++; if (lat !== 35) begin errors++; $display("FAIL abort_fresh_latency got=%0d exp=35", lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
